// File: rtl/elev_pkg.sv
// Shared types, default timing constants and pending-call scan helpers for the
// N-floor elevator controller.
package elev_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MOVE = 2'd1,
    S_DOOR = 2'd2,
    S_HALT = 2'd3
  } elev_state_e;

  localparam int DEF_TRAVEL_TICKS = 100;
  localparam int DEF_DOOR_TICKS   = 150;

  // Helpers take the widest legal call vector (16 floors); callers zero-extend.
  function automatic logic any_above(input logic [15:0] pend, input logic [3:0] flr);
    logic r;
    r = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (pend[i] && (i > int'(flr))) r = 1'b1;
    end
    return r;
  endfunction

  function automatic logic any_below(input logic [15:0] pend, input logic [3:0] flr);
    logic r;
    r = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (pend[i] && (i < int'(flr))) r = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/elev_timer.sv
// Tick counter shared by travel, door dwell and parking; clear has priority
// over increment, and holding both low freezes the count.
module elev_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic [W-1:0] last_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (inc_i) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // Terminal count only; the caller qualifies it with its tick.
  assign tc_o = (cnt_q == last_i);

endmodule

// File: rtl/elevator_ctrl_n.sv
// N-floor SCAN elevator controller. Define ELEV_PARK_EN to make an idle car
// return to floor 0 after a period with no calls.
module elevator_ctrl_n
  import elev_pkg::*;
#(
  parameter int N_FLOORS     = 4,
  parameter int TRAVEL_TICKS = DEF_TRAVEL_TICKS,
  parameter int DOOR_TICKS   = DEF_DOOR_TICKS,
  parameter int TCNT_W       = 8,
  localparam int FLOOR_W     = $clog2(N_FLOORS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic                start_stop,
  input  logic [N_FLOORS-1:0] req,
  output logic [FLOOR_W-1:0]  floor,
  output logic [1:0]          state,
  output logic                dir_up,
  output logic                door_open,
  output logic [N_FLOORS-1:0] pending
);

`ifdef ELEV_PARK_EN
  localparam int PARK_TICKS = 500;
  localparam int TW = (TCNT_W > 9) ? TCNT_W : 9;
  logic park_q, park_d;
`else
  localparam int TW = TCNT_W;
`endif

  elev_state_e         state_q, state_d;
  logic [FLOOR_W-1:0]  floor_q, floor_d, nf;
  logic                dir_q, dir_d, door_q;
  logic [N_FLOORS-1:0] pending_q, pending_d, pend_nxt;
  logic                t_clr, t_inc, t_tc;
  logic [TW-1:0]       t_last;
  logic                above, below, ahead_n, park_hold;

  always_comb begin
    case (state_q)
      S_MOVE, S_HALT: t_last = TW'(TRAVEL_TICKS - 1);
      S_DOOR:         t_last = TW'(DOOR_TICKS - 1);
`ifdef ELEV_PARK_EN
      default:        t_last = TW'(PARK_TICKS - 1);
`else
      default:        t_last = '0;
`endif
    endcase
  end

  elev_timer #(.W(TW)) u_timer (
    .clk    (clk),
    .rst_n  (reset),
    .clr_i  (t_clr),
    .inc_i  (t_inc),
    .last_i (t_last),
    .tc_o   (t_tc)
  );

  always_comb begin
    state_d   = state_q;
    floor_d   = floor_q;
    dir_d     = dir_q;
    t_clr     = 1'b0;
    t_inc     = 1'b0;
    park_hold = 1'b0;
`ifdef ELEV_PARK_EN
    park_d    = park_q;
`endif
    // A call for the floor the car is standing at is served, never latched.
    pend_nxt = pending_q | req;
    if (state_q == S_IDLE || state_q == S_DOOR) pend_nxt[floor_q] = 1'b0;
    pending_d = pend_nxt;
    nf      = dir_q ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);
    above   = any_above(16'(pend_nxt), 4'(floor_q));
    below   = any_below(16'(pend_nxt), 4'(floor_q));
    ahead_n = dir_q ? any_above(16'(pend_nxt), 4'(nf)) : any_below(16'(pend_nxt), 4'(nf));

    case (state_q)
      S_IDLE: begin
        t_clr = 1'b1;
        if (req[floor_q]) begin
          state_d = S_DOOR;
        end else if (start_stop && (pend_nxt != '0)) begin
          state_d = S_MOVE;
          if (dir_q ? !above : !below) dir_d = !dir_q;
        end
`ifdef ELEV_PARK_EN
        else if (start_stop && (floor_q != '0)) begin
          t_clr = 1'b0;
          t_inc = tick;
          if (tick && t_tc) begin
            state_d = S_MOVE;
            dir_d   = 1'b0;
            park_d  = 1'b1;
            t_clr   = 1'b1;
          end
        end
`endif
      end
      S_MOVE: begin
        if (!start_stop) begin
          state_d = S_HALT;
        end else if (tick) begin
          t_inc = 1'b1;
          if (t_tc) begin
            t_clr   = 1'b1;
            floor_d = nf;
`ifdef ELEV_PARK_EN
            park_hold = park_q && (pend_nxt == '0) && (nf != '0);
            if (!park_hold) park_d = 1'b0;
`endif
            if (!park_hold) begin
              if (pend_nxt[nf]) begin
                state_d       = S_DOOR;
                pending_d[nf] = 1'b0;
              end else if (!ahead_n) begin
                state_d = S_IDLE;
              end
            end
          end
        end
      end
      S_DOOR: begin
        if (req[floor_q]) begin
          t_clr = 1'b1;
        end else if (tick) begin
          t_inc = 1'b1;
          if (t_tc) begin
            state_d = S_IDLE;
            t_clr   = 1'b1;
          end
        end
      end
      default: begin
        if (start_stop) state_d = S_MOVE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      floor_q   <= '0;
      dir_q     <= 1'b1;
      door_q    <= 1'b0;
      pending_q <= '0;
`ifdef ELEV_PARK_EN
      park_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      floor_q   <= floor_d;
      dir_q     <= dir_d;
      door_q    <= (state_d == S_DOOR);
      pending_q <= pending_d;
`ifdef ELEV_PARK_EN
      park_q    <= park_d;
`endif
    end
  end

  a_floor_range: assert property (@(posedge clk) disable iff (!reset)
    (state_q == S_MOVE && start_stop && tick && t_tc) |->
      (dir_q ? (floor_q != FLOOR_W'(N_FLOORS - 1)) : (floor_q != '0)));

  assign floor     = floor_q;
  assign state     = state_q;
  assign dir_up    = dir_q;
  assign door_open = door_q;
  assign pending   = pending_q;

endmodule

// File: tb/tb_elevator_ctrl_n.sv
// Directed scenario bench for elevator_ctrl_n (4 floors, 100/150 tick timing).
module tb_elevator_ctrl_n;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MOVE = 2'd1;
  localparam logic [1:0] DOOR = 2'd2;
  localparam logic [1:0] HALT = 2'd3;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic       start_stop;
  logic [3:0] req;
  logic [1:0] floor;
  logic [1:0] state;
  logic       dir_up;
  logic       door_open;
  logic [3:0] pending;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  elevator_ctrl_n #(
    .N_FLOORS(4), .TRAVEL_TICKS(100), .DOOR_TICKS(150), .TCNT_W(8)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .start_stop(start_stop), .req(req),
    .floor(floor), .state(state), .dir_up(dir_up), .door_open(door_open), .pending(pending)
  );

  // Each tick is one clock high followed by one clock low; returns on a negedge.
  task automatic ticks(input int n);
    repeat (n) begin
      @(negedge clk); tick = 1'b1;
      @(negedge clk); tick = 1'b0;
    end
  endtask

  task automatic pulse_req(input logic [3:0] r);
    @(negedge clk); req = r;
    @(negedge clk); req = '0;
  endtask

  task automatic test_reset;
    reset = 1'b0; tick = 1'b0; start_stop = 1'b1; req = '0;
    repeat (3) @(negedge clk);
    total++; if (floor !== 2'd0) begin bad++; $display("FAIL rst_floor got=%0d exp=0", floor); end
    total++; if (state !== IDLE) begin bad++; $display("FAIL rst_state got=%0d exp=0", state); end
    total++; if (dir_up !== 1'b1) begin bad++; $display("FAIL rst_dir got=%0b exp=1", dir_up); end
    total++; if (door_open !== 1'b0) begin bad++; $display("FAIL rst_door got=%0b exp=0", door_open); end
    total++; if (pending !== 4'b0000) begin bad++; $display("FAIL rst_pending got=%b exp=0000", pending); end
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_single_call;
    pulse_req(4'b0100);
    total++; if (state !== MOVE) begin bad++; $display("FAIL t1_start state=%0d exp=1", state); end
    total++; if (pending !== 4'b0100) begin bad++; $display("FAIL t1_latch pending=%b exp=0100", pending); end
    ticks(99);
    total++; if (floor !== 2'd0) begin bad++; $display("FAIL t1_f0_hold floor=%0d exp=0", floor); end
    ticks(1);
    total++; if (floor !== 2'd1 || state !== MOVE) begin bad++; $display("FAIL t1_f1 floor=%0d state=%0d exp=1/1", floor, state); end
    ticks(100);
    total++; if (floor !== 2'd2 || state !== DOOR) begin bad++; $display("FAIL t1_f2 floor=%0d state=%0d exp=2/2", floor, state); end
    total++; if (door_open !== 1'b1 || pending !== 4'b0000) begin bad++; $display("FAIL t1_door door=%0b pending=%b exp=1/0000", door_open, pending); end
    ticks(149);
    total++; if (state !== DOOR) begin bad++; $display("FAIL t1_dwell state=%0d exp=2", state); end
    ticks(1);
    total++; if (state !== IDLE || door_open !== 1'b0) begin bad++; $display("FAIL t1_close state=%0d door=%0b exp=0/0", state, door_open); end
  endtask

  task automatic test_sweep_reverse;
    pulse_req(4'b1001);
    total++; if (state !== MOVE || dir_up !== 1'b1 || pending !== 4'b1001) begin bad++; $display("FAIL t2_start state=%0d dir=%0b pending=%b exp=1/1/1001", state, dir_up, pending); end
    ticks(100);
    total++; if (floor !== 2'd3 || state !== DOOR || pending !== 4'b0001) begin bad++; $display("FAIL t2_f3 floor=%0d state=%0d pending=%b exp=3/2/0001", floor, state, pending); end
    ticks(150);
    total++; if (state !== IDLE || dir_up !== 1'b1) begin bad++; $display("FAIL t2_idle state=%0d dir=%0b exp=0/1", state, dir_up); end
    @(negedge clk);
    total++; if (state !== MOVE || dir_up !== 1'b0) begin bad++; $display("FAIL t2_reverse state=%0d dir=%0b exp=1/0", state, dir_up); end
    ticks(300);
    total++; if (floor !== 2'd0 || state !== DOOR || pending !== 4'b0000) begin bad++; $display("FAIL t2_f0 floor=%0d state=%0d pending=%b exp=0/2/0000", floor, state, pending); end
    ticks(150);
    total++; if (state !== IDLE || dir_up !== 1'b0) begin bad++; $display("FAIL t2_end state=%0d dir=%0b exp=0/0", state, dir_up); end
  endtask

  task automatic test_pickup_on_way;
    pulse_req(4'b1000);
    total++; if (state !== MOVE || dir_up !== 1'b1) begin bad++; $display("FAIL t3_start state=%0d dir=%0b exp=1/1", state, dir_up); end
    ticks(50);
    pulse_req(4'b0010);
    total++; if (pending !== 4'b1010) begin bad++; $display("FAIL t3_latch pending=%b exp=1010", pending); end
    ticks(50);
    total++; if (floor !== 2'd1 || state !== DOOR || pending !== 4'b1000) begin bad++; $display("FAIL t3_stop1 floor=%0d state=%0d pending=%b exp=1/2/1000", floor, state, pending); end
    ticks(150);
    @(negedge clk);
    total++; if (state !== MOVE || dir_up !== 1'b1) begin bad++; $display("FAIL t3_resume state=%0d dir=%0b exp=1/1", state, dir_up); end
    ticks(200);
    total++; if (floor !== 2'd3 || state !== DOOR || dir_up !== 1'b1) begin bad++; $display("FAIL t3_f3 floor=%0d state=%0d dir=%0b exp=3/2/1", floor, state, dir_up); end
    ticks(150);
    total++; if (state !== IDLE) begin bad++; $display("FAIL t3_end state=%0d exp=0", state); end
  endtask

  task automatic test_halt;
    pulse_req(4'b0100);
    total++; if (state !== MOVE || dir_up !== 1'b0) begin bad++; $display("FAIL t4_start state=%0d dir=%0b exp=1/0", state, dir_up); end
    ticks(50);
    @(negedge clk); start_stop = 1'b0;
    @(negedge clk);
    total++; if (state !== HALT) begin bad++; $display("FAIL t4_halt state=%0d exp=3", state); end
    ticks(300);
    total++; if (floor !== 2'd3 || state !== HALT) begin bad++; $display("FAIL t4_frozen floor=%0d state=%0d exp=3/3", floor, state); end
    @(negedge clk); start_stop = 1'b1;
    @(negedge clk);
    total++; if (state !== MOVE) begin bad++; $display("FAIL t4_resume state=%0d exp=1", state); end
    ticks(49);
    total++; if (floor !== 2'd3) begin bad++; $display("FAIL t4_early floor=%0d exp=3", floor); end
    ticks(1);
    total++; if (floor !== 2'd2 || state !== DOOR) begin bad++; $display("FAIL t4_arrive floor=%0d state=%0d exp=2/2", floor, state); end
  endtask

  task automatic test_door_restart;
    ticks(140);
    pulse_req(4'b0100);
    total++; if (state !== DOOR || pending !== 4'b0000) begin bad++; $display("FAIL t5_req state=%0d pending=%b exp=2/0000", state, pending); end
    ticks(149);
    total++; if (state !== DOOR || door_open !== 1'b1) begin bad++; $display("FAIL t5_extended state=%0d door=%0b exp=2/1", state, door_open); end
    ticks(1);
    total++; if (state !== IDLE || door_open !== 1'b0 || pending !== 4'b0000) begin bad++; $display("FAIL t5_close state=%0d door=%0b pending=%b exp=0/0/0000", state, door_open, pending); end
  endtask

  task automatic test_clear_wins;
    pulse_req(4'b0010);
    total++; if (state !== MOVE || dir_up !== 1'b0) begin bad++; $display("FAIL t6_start state=%0d dir=%0b exp=1/0", state, dir_up); end
    ticks(99);
    @(negedge clk); tick = 1'b1; req = 4'b0010;
    @(negedge clk); tick = 1'b0; req = '0;
    total++; if (floor !== 2'd1 || state !== DOOR || pending !== 4'b0000) begin bad++; $display("FAIL t6_arrive floor=%0d state=%0d pending=%b exp=1/2/0000", floor, state, pending); end
    ticks(150);
    total++; if (state !== IDLE) begin bad++; $display("FAIL t6_end state=%0d exp=0", state); end
  endtask

  task automatic test_park;
`ifdef ELEV_PARK_EN
    ticks(499);
    total++; if (state !== IDLE || floor !== 2'd1) begin bad++; $display("FAIL t7_wait state=%0d floor=%0d exp=0/1", state, floor); end
    ticks(1);
    total++; if (state !== MOVE || dir_up !== 1'b0) begin bad++; $display("FAIL t7_go state=%0d dir=%0b exp=1/0", state, dir_up); end
    for (int i = 0; i < 100; i++) begin
      ticks(1);
      total++; if (door_open !== 1'b0) begin bad++; $display("FAIL t7_door tick=%0d door=%0b exp=0", i, door_open); end
    end
    total++; if (floor !== 2'd0 || state !== IDLE) begin bad++; $display("FAIL t7_parked floor=%0d state=%0d exp=0/0", floor, state); end
`else
    ticks(700);
    total++; if (floor !== 2'd1 || state !== IDLE || door_open !== 1'b0) begin bad++; $display("FAIL t7_stay floor=%0d state=%0d door=%0b exp=1/0/0", floor, state, door_open); end
`endif
  endtask

  task automatic test_reset_mid_move;
    pulse_req(4'b1000);
    ticks(150);
    total++; if (state !== MOVE || floor === 2'd0) begin bad++; $display("FAIL t8_moving state=%0d floor=%0d exp=1/nonzero", state, floor); end
    #2 reset = 1'b0;
    #1;
    total++; if (floor !== 2'd0 || state !== IDLE) begin bad++; $display("FAIL t8_async floor=%0d state=%0d exp=0/0", floor, state); end
    total++; if (pending !== 4'b0000 || dir_up !== 1'b1) begin bad++; $display("FAIL t8_regs pending=%b dir=%0b exp=0000/1", pending, dir_up); end
    @(negedge clk); reset = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_single_call;
    test_sweep_reverse;
    test_pickup_on_way;
    test_halt;
    test_door_restart;
    test_clear_wins;
    test_park;
    test_reset_mid_move;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/elevator_ctrl_n.md
Name: elevator_ctrl_n

Overview:
- Parametrised N-floor elevator controller; successor to the fixed two-floor logic unit fed by the keypad/debounce chain.
- Latches per-floor call requests and serves them in SCAN order: keep direction while calls remain ahead, otherwise reverse.
- Sequences travel and door dwell from a slow tick enable.
- Exports floor, state, direction, door and pending-call status for the LED and 7-segment drivers.

Parameters:
- N_FLOORS, 4, number of floors, legal range 2..16.
- FLOOR_W, derived as clog2(N_FLOORS), width of the floor index (localparam).
- TRAVEL_TICKS, 100, ticks to travel one floor.
- DOOR_TICKS, 150, ticks the door stays open.
- TCNT_W, 8, timer width; must hold max(TRAVEL_TICKS, DOOR_TICKS).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- tick  in  1  one-clk enable pulse (50 Hz) advancing the timers.
- start_stop  in  1  level; 1 = run, 0 = halt motion.
- req  in  N_FLOORS  one-clk debounced call pulses, bit i = floor i.
- floor  out  FLOOR_W  current floor.
- state  out  2  IDLE=0, MOVE=1, DOOR=2, HALT=3.
- dir_up  out  1  1 = up, 0 = down.
- door_open  out  1  high exactly in DOOR.
- pending  out  N_FLOORS  latched unserved calls.

Behaviour:
- Reset (asynchronous, reset=0) values: floor=0, state=IDLE, dir_up=1, door_open=0, pending=0, timer=0.
- Request latching: every clk, pending |= req, except the current-floor bit when state is IDLE or DOOR. That bit is consumed immediately and never sets pending.
- above = pending has any bit > floor; below = pending has any bit < floor.
- IDLE:
  - Current-floor req → DOOR next clk, timer=0.
  - Else if start_stop=1 and pending≠0: if dir_up and above → MOVE.
  - Else if !dir_up and below → MOVE.
  - Else reverse dir_up → MOVE, in the same cycle.
  - With start_stop=0, stay in IDLE; requests still latch.
- MOVE:
  - Timer increments on tick.
  - On the tick where timer==TRAVEL_TICKS-1: floor ±1 per dir_up, timer=0.
  - Then evaluate the new floor: pending[new floor] set → DOOR and clear that bit in the same cycle.
  - Else if calls remain ahead in dir_up → stay in MOVE.
  - Else → IDLE.
- start_stop=0 in MOVE → HALT next clk; timer frozen.
- HALT: start_stop=1 → MOVE, timer resumes from its frozen value. Requests keep latching.
- DOOR:
  - door_open=1; timer increments on tick.
  - timer==DOOR_TICKS-1 on tick → IDLE, timer=0.
  - Current-floor req during DOOR restarts timer=0.
  - start_stop has no effect in DOOR.
- Boundaries:
  - floor is never decremented at 0 or incremented at N_FLOORS-1. Direction logic guarantees this; an assertion checks it.
  - req and a clear of the same bit in one cycle: the clear wins only if that bit is the current floor at the DOOR entry. Otherwise the bit sets.
  - reset mid-MOVE returns floor to 0 immediately.
- Outputs are all registered; door_open and state change one clk after the deciding edge/tick.

Optional Feature:
- Macro: ELEV_PARK_EN.
- Defined:
  - Adds localparam PARK_TICKS=500.
  - When in IDLE with pending=0 and floor≠0 for PARK_TICKS consecutive ticks, sets dir_up=0 and enters MOVE toward floor 0 without opening the door there.
  - Any req aborts parking at the next floor evaluation and normal SCAN applies.
- Undefined: the car stays at its last floor indefinitely.

Decomposition:
- Package elev_pkg: state encodings (IDLE/MOVE/DOOR/HALT), default tick constants, and functions any_above(pending, floor) and any_below(pending, floor).
- Sub-module elev_timer: tick counter with clear, freeze and terminal-count compare. Instantiated once and shared by travel, door and park timing.

Test Plan:
- reset released; req[2] pulse, start_stop=1 → MOVE; floor 1 after 100 ticks, floor 2 after 200; DOOR with door_open=1 for 150 ticks; then IDLE, pending=0.
- At floor 0: req[3] then, mid-travel to floor 1, req[1] → stops at 1 (DOOR), then continues to 3, dir_up stays 1.
- At floor 2 going up with pending={0,3} → serves 3, then dir_up=0, travels to 0; pending=0 at end.
- start_stop=0 at tick 50 of a travel → HALT, floor unchanged for 300 ticks; start_stop=1 → arrives 50 ticks later.
- In DOOR at floor 1: req[1] at tick 140 → door stays open until tick 290 total; req[1] never appears in pending.
- With ELEV_PARK_EN, idle at floor 3 with no calls → after 500 ticks returns to floor 0 with door_open=0 throughout; without the macro, floor stays 3.
